qoi_full_pixel_encoder_v2: RTL and testbench
============================================

Name: qoi_full_pixel_encoder_v2

Overview:
Parametrised successor to the single-pixel full-colour encoder. Emits one QOI full-pixel op per accepted pixel: QOI_OP_RGB (0xFE) or QOI_OP_RGBA (0xFF). The op is chosen from the alpha change against the previous pixel, or forced to RGBA. Sits between the pixel source and the byte-stream packer, with valid/ready backpressure on both sides and a frame-start sideband that restarts the previous-pixel history.

Parameters:
COMPONENTS, 4, image components; legal values 3 (RGB) or 4 (RGBA); other values are an elaboration error.
FORCE_RGBA, 0, when 1 and COMPONENTS==4, every pixel is emitted as QOI_OP_RGBA.

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
pixel  input  8*COMPONENTS  R in [8C-1:8C-8], then G, then B; A in [7:0] when COMPONENTS==4
pixel_valid  input  1  pixel/frame_start valid
frame_start  input  1  first pixel of a frame; qualified by pixel_valid
pixel_ready  output  1  encoder accepts pixel this cycle
ostream  output  8  output byte
wr_en  output  1  ostream valid
wr_ready  input  1  downstream accepts ostream this cycle
op_last  output  1  current ostream byte is the final byte of its op
is_rgba  output  1  current op is QOI_OP_RGBA; valid while wr_en

Behaviour:
- Reset, synchronous, active-high, dominates everything else. Next cycle: wr_en=0, ostream=0x00, op_last=0, is_rgba=0, state=IDLE, prev_alpha=0xFF, pixbuf=0. Reset mid-op discards the op; no partial bytes follow.
- Accept = pixel_valid & pixel_ready. pixel_ready = (state==IDLE) | (wr_en & op_last & wr_ready). This is combinational from wr_ready, so back-to-back ops run with no bubble.
- On accept:
  - Capture pixel into pixbuf.
  - Compute ref_alpha = frame_start ? 0xFF : prev_alpha.
  - rgba_sel = (COMPONENTS==4) & (FORCE_RGBA | pixel[7:0]!=ref_alpha).
  - If COMPONENTS==4, update prev_alpha to pixel[7:0]; with COMPONENTS==3 alpha is implicitly 0xFF.
  - Move to TAG.
- Latency: tag byte appears with wr_en=1 on the cycle after accept.
- States: IDLE, TAG, R, G, B, A.
  - IDLE: wr_en=0.
  - TAG: ostream = rgba_sel ? 0xFF : 0xFE.
  - R, G, B, A: ostream is the corresponding pixbuf byte.
  - A is visited only if rgba_sel.
  - op_last=1 in B when !rgba_sel, and in A when rgba_sel.
- Advance only when wr_en & wr_ready. Otherwise ostream, wr_en, op_last and is_rgba hold stable; no output may change while stalled.
- On the last byte handshake: go to TAG if a pixel is accepted in the same cycle, else go to IDLE.
- Op length: 4 bytes (RGB) or 5 bytes (RGBA). Peak throughput is one byte per cycle.
- pixel is sampled only on accept; changes to pixel while an op is in flight have no effect.
- frame_start without pixel_valid is ignored. frame_start on an accepted pixel resets history before comparison.
- pixel_valid may drop without acceptance; there is no obligation to hold.
- wr_ready is ignored while wr_en=0.

Test Plan:
- RGBA, first pixel 0x11223344 with frame_start=1, wr_ready=1 -> FF 11 22 33 44; op_last only on 0x44; is_rgba=1; tag appears 1 cycle after accept.
- RGBA, pixel 0xAABBCCFF after reset, then 0x010203FF -> FE AA BB CC, then FE 01 02 03 (alpha unchanged); back-to-back with zero idle cycles; pixel_ready high on each op_last cycle.
- COMPONENTS=3, pixels 0x102030 then 0x405060 -> FE 10 20 30 FE 40 50 60; is_rgba never 1.
- FORCE_RGBA=1, pixel 0x000000FF -> FF 00 00 00 FF. Then frame_start with 0x000000FF, FORCE_RGBA=0 build -> FE 00 00 00.
- Backpressure: toggle wr_ready pseudo-randomly over 50 pixels -> byte stream identical to wr_ready=1 run; outputs stable during every stall; pixel_ready low mid-op.
- Reset asserted during R byte of an RGBA op -> next cycle wr_en=0; next pixel 0x000000FF emits FE (prev_alpha restored to 0xFF).

Source files
------------

// File: rtl/qoi_full_pixel_encoder_v2.sv
// QOI full-pixel encoder: one QOI_OP_RGB / QOI_OP_RGBA op per accepted pixel, with
// valid/ready on both sides and a frame_start sideband that restarts the alpha history.
module qoi_full_pixel_encoder_v2 #(
  parameter int unsigned COMPONENTS = 4,
  parameter bit          FORCE_RGBA = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [8*COMPONENTS-1:0] pixel,
  input  logic                    pixel_valid,
  input  logic                    frame_start,
  output logic                    pixel_ready,
  output logic [7:0]              ostream,
  output logic                    wr_en,
  input  logic                    wr_ready,
  output logic                    op_last,
  output logic                    is_rgba
);

  if (COMPONENTS != 3 && COMPONENTS != 4) begin : g_bad_components
    $error("qoi_full_pixel_encoder_v2: COMPONENTS must be 3 or 4");
  end

  localparam int unsigned PW       = 8 * COMPONENTS;
  localparam bit          HasAlpha = (COMPONENTS == 4);

  typedef enum logic [2:0] {StIdle, StTag, StR, StG, StB, StA} state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] pixbuf_q, pixbuf_d;
  logic          rgba_sel_q, rgba_sel_d;
  logic [7:0]    prev_alpha_q, prev_alpha_d;
  logic [7:0]    ref_alpha;
  logic          accept;
  logic          advance;

  // Outputs are decoded from registered state only, so they cannot move during a stall.
  always_comb begin
    wr_en   = 1'b0;
    ostream = 8'h00;
    op_last = 1'b0;
    unique case (state_q)
      StIdle: ;
      StTag: begin
        wr_en   = 1'b1;
        ostream = rgba_sel_q ? 8'hFF : 8'hFE;
      end
      StR: begin
        wr_en   = 1'b1;
        ostream = pixbuf_q[PW-1 -: 8];
      end
      StG: begin
        wr_en   = 1'b1;
        ostream = pixbuf_q[PW-9 -: 8];
      end
      StB: begin
        wr_en   = 1'b1;
        ostream = pixbuf_q[PW-17 -: 8];
        op_last = !rgba_sel_q;
      end
      StA: begin
        wr_en   = 1'b1;
        ostream = pixbuf_q[7:0];
        op_last = 1'b1;
      end
      default: ;
    endcase
    is_rgba = wr_en & rgba_sel_q;
  end

  assign advance     = wr_en & wr_ready;
  assign pixel_ready = (state_q == StIdle) | (wr_en & op_last & wr_ready);
  assign accept      = pixel_valid & pixel_ready;
  assign ref_alpha   = frame_start ? 8'hFF : prev_alpha_q;

  always_comb begin
    state_d      = state_q;
    pixbuf_d     = pixbuf_q;
    rgba_sel_d   = rgba_sel_q;
    prev_alpha_d = prev_alpha_q;

    if (accept) begin
      pixbuf_d   = pixel;
      rgba_sel_d = HasAlpha && (FORCE_RGBA || (pixel[7:0] != ref_alpha));
      if (HasAlpha) prev_alpha_d = pixel[7:0];
    end

    unique case (state_q)
      StIdle: if (accept) state_d = StTag;
      StTag:  if (advance) state_d = StR;
      StR:    if (advance) state_d = StG;
      StG:    if (advance) state_d = StB;
      // A new pixel can only be accepted on the op's final byte handshake.
      StB:    if (advance) state_d = rgba_sel_q ? StA : (accept ? StTag : StIdle);
      StA:    if (advance) state_d = accept ? StTag : StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      pixbuf_q     <= '0;
      rgba_sel_q   <= 1'b0;
      prev_alpha_q <= 8'hFF;
    end else begin
      state_q      <= state_d;
      pixbuf_q     <= pixbuf_d;
      rgba_sel_q   <= rgba_sel_d;
      prev_alpha_q <= prev_alpha_d;
    end
  end

endmodule

// File: tb/tb_qoi_full_pixel_encoder_v2.sv
// Bench for qoi_full_pixel_encoder_v2: three builds (RGBA, RGB-only, forced RGBA) checked
// against a pixel-level op model; stream entries are {byte, op_last, is_rgba}.
module tb_qoi_full_pixel_encoder_v2;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic [31:0] pixel;
  logic        pixel_valid, frame_start, pixel_ready, wr_en, wr_ready, op_last, is_rgba;
  logic [7:0]  ostream;

  logic [23:0] pixel3;
  logic        pv3, fs3, rdy3, wen3, wrr3, last3, rgba3;
  logic [7:0]  os3;

  logic [31:0] pixelf;
  logic        pvf, fsf, rdyf, wenf, wrrf, lastf, rgbaf;
  logic [7:0]  osf;

  qoi_full_pixel_encoder_v2 #(.COMPONENTS(4), .FORCE_RGBA(1'b0)) dut (
    .clk(clk), .rst(rst), .pixel(pixel), .pixel_valid(pixel_valid),
    .frame_start(frame_start), .pixel_ready(pixel_ready), .ostream(ostream),
    .wr_en(wr_en), .wr_ready(wr_ready), .op_last(op_last), .is_rgba(is_rgba)
  );

  qoi_full_pixel_encoder_v2 #(.COMPONENTS(3), .FORCE_RGBA(1'b0)) dut3 (
    .clk(clk), .rst(rst), .pixel(pixel3), .pixel_valid(pv3),
    .frame_start(fs3), .pixel_ready(rdy3), .ostream(os3),
    .wr_en(wen3), .wr_ready(wrr3), .op_last(last3), .is_rgba(rgba3)
  );

  qoi_full_pixel_encoder_v2 #(.COMPONENTS(4), .FORCE_RGBA(1'b1)) dutf (
    .clk(clk), .rst(rst), .pixel(pixelf), .pixel_valid(pvf),
    .frame_start(fsf), .pixel_ready(rdyf), .ostream(osf),
    .wr_en(wenf), .wr_ready(wrrf), .op_last(lastf), .is_rgba(rgbaf)
  );

  int          checks = 0;
  int          errors = 0;
  logic [9:0]  exp_q[$];
  logic [9:0]  obs_q[$];
  logic [31:0] px_q[$];
  bit          fs_q[$];
  logic [7:0]  m_prev;
  int          stall_err, ready_err, idle_cnt, first_acc, first_wen;

  // Reference: the full op a pixel must produce, given the alpha history.
  function automatic void model_op(input logic [31:0] p, input bit fs, input bit has_a,
                                   input bit force_a);
    logic [7:0] r, g, b, a, ref_a;
    bit rgba;
    if (has_a) {r, g, b, a} = p;
    else begin
      {r, g, b} = p[23:0];
      a = 8'hFF;
    end
    ref_a  = fs ? 8'hFF : m_prev;
    rgba   = has_a && (force_a || a != ref_a);
    m_prev = a;
    exp_q.push_back({rgba ? 8'hFF : 8'hFE, 1'b0, rgba});
    exp_q.push_back({r, 1'b0, rgba});
    exp_q.push_back({g, 1'b0, rgba});
    exp_q.push_back({b, !rgba, rgba});
    if (rgba) exp_q.push_back({a, 1'b1, 1'b1});
  endfunction

  function automatic void add_px(input logic [31:0] p, input bit fs);
    px_q.push_back(p);
    fs_q.push_back(fs);
    model_op(p, fs, 1'b1, 1'b0);
  endfunction

  function automatic int first_diff();
    int n = (obs_q.size() > exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      if (i >= obs_q.size() || i >= exp_q.size() || obs_q[i] !== exp_q[i]) return i;
    return -1;
  endfunction

  function automatic logic [9:0] obs_at(input int i);
    return (i >= 0 && i < obs_q.size()) ? obs_q[i] : 10'bx;
  endfunction

  function automatic logic [9:0] exp_at(input int i);
    return (i >= 0 && i < exp_q.size()) ? exp_q[i] : 10'bx;
  endfunction

  function automatic void clear_all();
    exp_q.delete();
    obs_q.delete();
    px_q.delete();
    fs_q.delete();
  endfunction

  // Feeds px_q into the main DUT, optionally with random wr_ready and pixel_valid gaps.
  task automatic drive(input bit bp);
    int sent = 0;
    int cyc = 0;
    bit stalled = 0;
    logic [9:0] held = '0;
    obs_q.delete();
    stall_err = 0; ready_err = 0; idle_cnt = 0; first_acc = -1; first_wen = -1;
    forever begin
      @(negedge clk);
      if (stalled && (!wr_en || {ostream, op_last, is_rgba} !== held)) stall_err++;
      if (sent == px_q.size() && !wr_en) break;
      if (cyc >= 4000) begin
        checks++; errors++;
        $display("FAIL drive_timeout: sent %0d of %0d pixels", sent, px_q.size());
        break;
      end
      wr_ready    = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      pixel_valid = (sent < px_q.size()) && (!bp || $urandom_range(0, 3) != 0);
      if (pixel_valid) begin
        pixel = px_q[sent];
        frame_start = fs_q[sent];
      end else begin
        pixel = $urandom;
        frame_start = 1'($urandom_range(0, 1));
      end
      #1;
      if (!wr_en) idle_cnt++;
      else if (first_wen < 0) first_wen = cyc;
      if (pixel_ready !== (!wr_en || (op_last && wr_ready))) ready_err++;
      if (wr_en && wr_ready) obs_q.push_back({ostream, op_last, is_rgba});
      if (pixel_valid && pixel_ready) begin
        if (first_acc < 0) first_acc = cyc;
        sent++;
      end
      stalled = wr_en && !wr_ready;
      held    = {ostream, op_last, is_rgba};
      cyc++;
    end
    pixel_valid = 1'b0;
    frame_start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    pixel = 32'h12345678; pixel_valid = 1'b1; frame_start = 1'b1; wr_ready = 1'b1;
    pixel3 = 24'h0; pv3 = 1'b1; fs3 = 1'b0; wrr3 = 1'b1;
    pixelf = 32'h0; pvf = 1'b1; fsf = 1'b0; wrrf = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %b want 0", wr_en); end
    checks++; if (ostream !== 8'h00) begin errors++; $display("FAIL reset_ostream: got %h want 00", ostream); end
    checks++; if (op_last !== 1'b0) begin errors++; $display("FAIL reset_op_last: got %b want 0", op_last); end
    checks++; if (is_rgba !== 1'b0) begin errors++; $display("FAIL reset_is_rgba: got %b want 0", is_rgba); end
    checks++; if (pixel_ready !== 1'b1) begin errors++; $display("FAIL reset_pixel_ready: got %b want 1", pixel_ready); end
    checks++; if (wen3 !== 1'b0 || wenf !== 1'b0) begin
      errors++; $display("FAIL reset_wr_en_builds: got %b%b want 00", wen3, wenf);
    end
    rst = 1'b0;
    pixel_valid = 1'b0; frame_start = 1'b0; pv3 = 1'b0; pvf = 1'b0;
    m_prev = 8'hFF;
  endtask

  task automatic test_rgba_first();
    int idx;
    test_reset();
    clear_all();
    add_px(32'h11223344, 1'b1);
    drive(1'b0);
    idx = first_diff();
    checks++; if (idx !== -1) begin
      errors++; $display("FAIL rgba_first_stream: entry %0d got %h want %h (%0d vs %0d entries)",
                         idx, obs_at(idx), exp_at(idx), obs_q.size(), exp_q.size());
    end
    checks++; if (first_wen !== first_acc + 1) begin
      errors++; $display("FAIL rgba_first_latency: tag at cycle %0d want %0d", first_wen, first_acc + 1);
    end
  endtask

  task automatic test_back_to_back();
    int idx;
    logic [31:0] p;
    test_reset();
    clear_all();
    add_px(32'hAABBCCFF, 1'b0);
    add_px(32'h010203FF, 1'b0);
    for (int i = 0; i < 8; i++) begin
      p = $urandom;
      if ($urandom_range(0, 1) != 0) p[7:0] = 8'hFF;
      add_px(p, $urandom_range(0, 3) == 0);
    end
    drive(1'b0);
    idx = first_diff();
    checks++; if (idx !== -1) begin
      errors++; $display("FAIL b2b_stream: entry %0d got %h want %h (%0d vs %0d entries)",
                         idx, obs_at(idx), exp_at(idx), obs_q.size(), exp_q.size());
    end
    checks++; if (idle_cnt !== 1) begin
      errors++; $display("FAIL b2b_idle_cycles: got %0d want 1", idle_cnt);
    end
    checks++; if (ready_err !== 0) begin
      errors++; $display("FAIL b2b_pixel_ready: %0d bad cycles want 0", ready_err);
    end
  endtask

  task automatic test_frame_start();
    int idx;
    clear_all();
    add_px(32'h00000010, 1'b0);
    add_px(32'h000000FF, 1'b1);
    add_px(32'h00000010, 1'b0);
    add_px(32'h00000010, 1'b1);
    drive(1'b0);
    idx = first_diff();
    checks++; if (idx !== -1) begin
      errors++; $display("FAIL frame_start_stream: entry %0d got %h want %h (%0d vs %0d entries)",
                         idx, obs_at(idx), exp_at(idx), obs_q.size(), exp_q.size());
    end
  endtask

  task automatic test_backpressure();
    int idx;
    logic [31:0] p;
    test_reset();
    clear_all();
    for (int i = 0; i < 50; i++) begin
      p = $urandom;
      if ($urandom_range(0, 2) == 0) p[7:0] = 8'hFF;
      add_px(p, $urandom_range(0, 5) == 0);
    end
    drive(1'b1);
    idx = first_diff();
    checks++; if (idx !== -1) begin
      errors++; $display("FAIL bp_stream: entry %0d got %h want %h (%0d vs %0d entries)",
                         idx, obs_at(idx), exp_at(idx), obs_q.size(), exp_q.size());
    end
    checks++; if (stall_err !== 0) begin
      errors++; $display("FAIL bp_stall_stable: %0d changed outputs want 0", stall_err);
    end
    checks++; if (ready_err !== 0) begin
      errors++; $display("FAIL bp_pixel_ready: %0d bad cycles want 0", ready_err);
    end
  endtask

  task automatic test_reset_mid_op();
    int idx;
    test_reset();
    clear_all();
    @(negedge clk);
    pixel = 32'h11223355; pixel_valid = 1'b1; frame_start = 1'b0; wr_ready = 1'b1;
    @(negedge clk);
    pixel_valid = 1'b0;
    @(negedge clk);
    checks++; if (wr_en !== 1'b1 || ostream !== 8'h11) begin
      errors++; $display("FAIL mid_op_r_byte: got wr_en=%b ostream=%h want 1/11", wr_en, ostream);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (wr_en !== 1'b0 || ostream !== 8'h00 || is_rgba !== 1'b0) begin
      errors++; $display("FAIL mid_op_reset: got wr_en=%b ostream=%h is_rgba=%b want 0/00/0",
                         wr_en, ostream, is_rgba);
    end
    m_prev = 8'hFF;
    add_px(32'h000000FF, 1'b0);
    drive(1'b0);
    idx = first_diff();
    checks++; if (idx !== -1) begin
      errors++; $display("FAIL mid_op_after_stream: entry %0d got %h want %h (%0d vs %0d entries)",
                         idx, obs_at(idx), exp_at(idx), obs_q.size(), exp_q.size());
    end
  endtask

  task automatic test_rgb3();
    int idx;
    int sent = 0;
    logic [23:0] p3 [4];
    test_reset();
    clear_all();
    p3[0] = 24'h102030; p3[1] = 24'h405060; p3[2] = 24'($urandom); p3[3] = 24'($urandom);
    for (int i = 0; i < 4; i++) model_op({8'h00, p3[i]}, i == 0, 1'b0, 1'b0);
    wrr3 = 1'b1;
    for (int cyc = 0; cyc < 60; cyc++) begin
      @(negedge clk);
      if (sent == 4 && !wen3) break;
      pv3 = (sent < 4);
      if (sent < 4) pixel3 = p3[sent];
      fs3 = (sent == 0);
      #1;
      if (wen3 && wrr3) obs_q.push_back({os3, last3, rgba3});
      if (pv3 && rdy3) sent++;
    end
    pv3 = 1'b0;
    idx = first_diff();
    checks++; if (idx !== -1) begin
      errors++; $display("FAIL rgb3_stream: entry %0d got %h want %h (%0d vs %0d entries)",
                         idx, obs_at(idx), exp_at(idx), obs_q.size(), exp_q.size());
    end
  endtask

  task automatic test_force_rgba();
    int idx;
    int sent = 0;
    logic [31:0] pf [4];
    test_reset();
    clear_all();
    pf[0] = 32'h000000FF; pf[1] = {$urandom} | 32'hFF; pf[2] = $urandom; pf[3] = 32'h000000FF;
    for (int i = 0; i < 4; i++) model_op(pf[i], i == 0, 1'b1, 1'b1);
    wrrf = 1'b1;
    for (int cyc = 0; cyc < 60; cyc++) begin
      @(negedge clk);
      if (sent == 4 && !wenf) break;
      pvf = (sent < 4);
      if (sent < 4) pixelf = pf[sent];
      fsf = (sent == 0);
      #1;
      if (wenf && wrrf) obs_q.push_back({osf, lastf, rgbaf});
      if (pvf && rdyf) sent++;
    end
    pvf = 1'b0;
    idx = first_diff();
    checks++; if (idx !== -1) begin
      errors++; $display("FAIL force_rgba_stream: entry %0d got %h want %h (%0d vs %0d entries)",
                         idx, obs_at(idx), exp_at(idx), obs_q.size(), exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_rgba_first();
    test_back_to_back();
    test_frame_start();
    test_backpressure();
    test_reset_mid_op();
    test_rgb3();
    test_force_rgba();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
